// File: rtl/demux3_18_buf_if.sv
// Bus bundle for demux3_18_buf.
//   in_*      : source-side transfer (valid/ready handshake, payload, destination select)
//   out_*     : shared payload, one-hot per-destination valid, per-destination ready
//   err_*     : error clear request, sticky invalid-select flag, saturating drop count
// Modports: master = source/sink driver (testbench side), slave = demux block.
interface demux3_18_buf_if #(
    parameter int unsigned CNT_W = 8
);
    localparam int unsigned DATA_W = 18;
    localparam int unsigned CTRL_W = 3;
    localparam int unsigned DEST_N = 7;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [DEST_N-1:0] out_valid;
    logic [DEST_N-1:0] out_ready;
    logic              err_clr;
    logic              err_sticky;
    logic [CNT_W-1:0]  err_cnt;

    modport master (
        output in_valid, in_data, in_ctrl, out_ready, err_clr,
        input  in_ready, out_data, out_valid, err_sticky, err_cnt
    );

    modport slave (
        input  in_valid, in_data, in_ctrl, out_ready, err_clr,
        output in_ready, out_data, out_valid, err_sticky, err_cnt
    );
endinterface

// File: rtl/demux3_18_buf.sv
// demux3_18_buf: 1-to-7 demultiplexer behind a 2-entry FIFO (head + skid).
// A 3-bit select picks one of seven destinations; select 011 is invalid and
// the transfer is dropped and counted. Entries leave in strict arrival order.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : demux3_18_buf_if slave modport (in_*, out_*, err_*)
module demux3_18_buf #(
    parameter int unsigned CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    demux3_18_buf_if.slave        bus
);
    localparam int unsigned DATA_W = 18;
    localparam int unsigned DEST_N = 7;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t            state;
    logic [DATA_W-1:0] head_data;
    logic [DEST_N-1:0] head_oh;
    logic [DATA_W-1:0] skid_data;
    logic [DEST_N-1:0] skid_oh;
    logic [CNT_W-1:0]  err_cnt_q;
    logic              err_sticky_q;

    logic [DEST_N-1:0] sel_oh;
    logic              sel_ok;
    logic              accept;
    logic              push;
    logic              drop;
    logic              drain;

    // Select decode; 011 is the single invalid code.
    always_comb begin
        sel_oh = '0;
        sel_ok = 1'b1;
        case (bus.in_ctrl)
            3'b000:  sel_oh = 7'b000_0001;
            3'b001:  sel_oh = 7'b000_0010;
            3'b010:  sel_oh = 7'b000_0100;
            3'b100:  sel_oh = 7'b000_1000;
            3'b101:  sel_oh = 7'b001_0000;
            3'b110:  sel_oh = 7'b010_0000;
            3'b111:  sel_oh = 7'b100_0000;
            default: sel_ok = 1'b0;
        endcase
    end

    // Ready depends on state only; gated by rst_n so it is low throughout reset.
    assign bus.in_ready = rst_n & (state != TWO);

    assign accept = bus.in_valid & bus.in_ready;
    assign push   = accept & sel_ok;
    assign drop   = accept & ~sel_ok;
    // Only the ready bit of the head's own destination matters.
    assign drain  = |(head_oh & bus.out_ready);

    // Buffer FSM with registered head outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            head_data <= '0;
            head_oh   <= '0;
            skid_data <= '0;
            skid_oh   <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        head_data <= bus.in_data;
                        head_oh   <= sel_oh;
                        state     <= ONE;
                    end
                end
                ONE: begin
                    if (push && drain) begin
                        // Pass-through: new entry replaces the departing head.
                        head_data <= bus.in_data;
                        head_oh   <= sel_oh;
                    end else if (push) begin
                        skid_data <= bus.in_data;
                        skid_oh   <= sel_oh;
                        state     <= TWO;
                    end else if (drain) begin
                        head_oh   <= '0;
                        state     <= EMPTY;
                    end
                end
                TWO: begin
                    // in_ready is low here, so only a drain can happen.
                    if (drain) begin
                        head_data <= skid_data;
                        head_oh   <= skid_oh;
                        state     <= ONE;
                    end
                end
                default: begin
                    state   <= EMPTY;
                    head_oh <= '0;
                end
            endcase
        end
    end

    // Error status; a drop coinciding with a clear leaves a count of one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q    <= '0;
            err_sticky_q <= 1'b0;
        end else if (bus.err_clr) begin
            err_cnt_q    <= drop ? CNT_W'(1) : '0;
            err_sticky_q <= drop;
        end else if (drop) begin
            err_sticky_q <= 1'b1;
            if (err_cnt_q != {CNT_W{1'b1}}) begin
                err_cnt_q <= err_cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.out_data   = head_data;
    assign bus.out_valid  = head_oh;
    assign bus.err_cnt    = err_cnt_q;
    assign bus.err_sticky = err_sticky_q;
endmodule
